// File: rtl/usi_spi_pkg.sv
// rtl/usi_spi_pkg.sv - shared state type, SPI mode constants and width helper
//   Contents: spi_state_e (IDLE/ACTIVE), CPOL_*/CPHA_* mode constants,
//             clog2() used to size the bit counter.
package usi_spi_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

   localparam logic CPOL_LOW   = 1'b0;
   localparam logic CPOL_HIGH  = 1'b1;
   localparam logic CPHA_LEAD  = 1'b0;  // sample on leading edge
   localparam logic CPHA_TRAIL = 1'b1;  // sample on trailing edge

   // Number of bits needed to count 0..value-1.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << i) < value) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/usi_spi_slave_if.sv
// rtl/usi_spi_slave_if.sv - bus-side word handshake of the USI SPI responder
//   TX: tx_data/tx_valid in, tx_ready out (shadow register empty).
//   RX: rx_data/rx_valid out, rx_ready in.
//   Status: busy, tx_underrun and rx_overrun pulses.
//   slave modport is used by usi_spi_slave, master modport by the bus side.
interface usi_spi_slave_if #(
   parameter int DW = 16
) ();
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          busy;
   logic          tx_underrun;
   logic          rx_overrun;

   modport slave (
      input  tx_data, tx_valid, rx_ready,
      output tx_ready, rx_data, rx_valid, busy, tx_underrun, rx_overrun
   );

   modport master (
      output tx_data, tx_valid, rx_ready,
      input  tx_ready, rx_data, rx_valid, busy, tx_underrun, rx_overrun
   );
endinterface

// File: rtl/usi_sync_edge.sv
// rtl/usi_sync_edge.sv - 2-flop synchronizer with edge detect on a third flop
//   clk, rst : system clock, async active-high reset
//   d_in     : asynchronous pad input
//   rise     : one-cycle pulse, synchronized input went 0->1
//   fall     : one-cycle pulse, synchronized input went 1->0
//   RST_VAL  : idle level loaded into all three flops on reset
module usi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic rise,
   output logic fall
);

   logic [2:0] sync_q;
   logic [2:0] sync_d;

   always_comb begin
      sync_d = {sync_q[1:0], d_in};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {3{RST_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   // sync_q[1] is the synchronized level, sync_q[2] its previous value.
   assign rise = sync_q[1] & ~sync_q[2];
   assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/usi_spi_slave.sv
// rtl/usi_spi_slave.sv - oversampling SPI responder with TX shadow and RX holding register
//   clk, rst          : system clock (>= 8x SCLK), async active-high reset
//   sclk_in, cs_n_in  : asynchronous SPI clock and active-low chip select
//   mosi_in           : serial data in
//   miso_out, miso_oe : serial data out and its pad enable
//   bus               : word handshake (usi_spi_slave_if.slave)
module usi_spi_slave
   import usi_spi_pkg::*;
#(
   parameter int            DW      = 16,
   parameter logic          CPOL    = 1'b0,
   parameter logic          CPHA    = 1'b0,
   parameter logic [DW-1:0] TX_IDLE = '0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           sclk_in,
   input  logic           cs_n_in,
   input  logic           mosi_in,
   output logic           miso_out,
   output logic           miso_oe,
   usi_spi_slave_if.slave bus
);

   localparam int CW = clog2(DW);

   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic lead_edge, trail_edge, sample_edge, shift_edge;

   spi_state_e    state_q, state_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [DW-1:0] tx_shift_q, tx_shift_d;
   logic [DW-1:0] rx_shift_q, rx_shift_d;
   logic [DW-1:0] shadow_q, shadow_d;
   logic          shadow_full_q, shadow_full_d;
   logic [DW-1:0] rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          load_pend_q, load_pend_d;
   logic          done_q, done_d;
   logic          miso_q, miso_d;
   logic          underrun_q, underrun_d;
   logic          overrun_q, overrun_d;
   logic [1:0]    mosi_q, mosi_d;
   logic          do_load;
   logic [DW-1:0] load_word;

   usi_sync_edge #(.RST_VAL(CPOL == CPOL_HIGH)) u_sclk_sync (
      .clk  (clk),
      .rst  (rst),
      .d_in (sclk_in),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   usi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
      .clk  (clk),
      .rst  (rst),
      .d_in (cs_n_in),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   // Leading edge leaves the idle level; which edge samples depends on CPHA.
   assign lead_edge   = (CPOL == CPOL_LOW) ? sclk_rise : sclk_fall;
   assign trail_edge  = (CPOL == CPOL_LOW) ? sclk_fall : sclk_rise;
   assign sample_edge = (CPHA == CPHA_LEAD) ? lead_edge : trail_edge;
   assign shift_edge  = (CPHA == CPHA_LEAD) ? trail_edge : lead_edge;

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      tx_shift_d    = tx_shift_q;
      rx_shift_d    = rx_shift_q;
      shadow_d      = shadow_q;
      shadow_full_d = shadow_full_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = rx_valid_q;
      load_pend_d   = load_pend_q;
      miso_d        = miso_q;
      done_d        = 1'b0;
      underrun_d    = 1'b0;
      overrun_d     = 1'b0;
      mosi_d        = {mosi_q[0], mosi_in};
      do_load       = 1'b0;
      // Load decision uses the shadow state before any same-cycle write.
      load_word     = shadow_full_q ? shadow_q : TX_IDLE;

      // A word completed last cycle; a same-cycle read frees the holding register.
      if (rx_valid_q && bus.rx_ready) begin
         rx_valid_d = 1'b0;
      end
      if (done_q) begin
         if (!rx_valid_q || bus.rx_ready) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d    = ACTIVE;
               bit_cnt_d  = '0;
               rx_shift_d = '0;
               if (CPHA == CPHA_TRAIL) begin
                  // First bit is driven at the first leading edge.
                  load_pend_d = 1'b1;
                  miso_d      = 1'b0;
               end else begin
                  do_load = 1'b1;
               end
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               // Abandon any partial frame; the shadow is left alone.
               state_d     = IDLE;
               bit_cnt_d   = '0;
               rx_shift_d  = '0;
               tx_shift_d  = '0;
               load_pend_d = 1'b0;
               miso_d      = 1'b0;
            end else begin
               // Reloads always land on a shift edge, in either phase mode.
               if (shift_edge) begin
                  if (load_pend_q) begin
                     do_load     = 1'b1;
                     load_pend_d = 1'b0;
                  end else begin
                     miso_d     = tx_shift_q[DW-2];
                     tx_shift_d = {tx_shift_q[DW-2:0], 1'b0};
                  end
               end
               if (sample_edge) begin
                  rx_shift_d = {rx_shift_q[DW-2:0], mosi_q[1]};
                  if (bit_cnt_q == CW'(DW - 1)) begin
                     bit_cnt_d   = '0;
                     done_d      = 1'b1;
                     load_pend_d = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (do_load) begin
         tx_shift_d = load_word;
         miso_d     = load_word[DW-1];
         if (shadow_full_q) begin
            shadow_full_d = 1'b0;
         end else begin
            underrun_d = 1'b1;
         end
      end

      if (bus.tx_valid && !shadow_full_q) begin
         shadow_d      = bus.tx_data;
         shadow_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         tx_shift_q    <= '0;
         rx_shift_q    <= '0;
         shadow_q      <= '0;
         shadow_full_q <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         load_pend_q   <= 1'b0;
         done_q        <= 1'b0;
         miso_q        <= 1'b0;
         underrun_q    <= 1'b0;
         overrun_q     <= 1'b0;
         mosi_q        <= '0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         tx_shift_q    <= tx_shift_d;
         rx_shift_q    <= rx_shift_d;
         shadow_q      <= shadow_d;
         shadow_full_q <= shadow_full_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         load_pend_q   <= load_pend_d;
         done_q        <= done_d;
         miso_q        <= miso_d;
         underrun_q    <= underrun_d;
         overrun_q     <= overrun_d;
         mosi_q        <= mosi_d;
      end
   end

   assign miso_out        = miso_q;
   assign miso_oe         = (state_q == ACTIVE);
   assign bus.busy        = (state_q == ACTIVE);
   assign bus.tx_ready    = ~shadow_full_q;
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.tx_underrun = underrun_q;
   assign bus.rx_overrun  = overrun_q;

endmodule
